lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Multi-cycle load/store unit for the RISC-V core. It sits directly downstream of the decoder and ALU, and replaces the fixed-count load delay trigger. It accepts one load or store per instruction, drives a variable-latency data-memory handshake with byte strobes and lane-shifted write data, and returns sign/zero-extended load data. It stalls the PC and register file until the access completes.

## Interface
- `ADDR_W`, default 32: width of the address bus.
- `TIMEOUT`, default 16: cycles to wait for `mem_ack` before aborting. 0 disables the timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: the current instruction is a load or store. Held stable until `stall` falls.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: instruction Funct3.
- `req_addr` in ADDR_W: ALU result (effective address).
- `req_wdata` in 32: rs2 data.
- `stall` out 1: hold PC and register-file write.
- `rd_valid` out 1: one-cycle pulse; load result is on `rd_data`.
- `rd_data` out 32: extended load result.
- `err` out 1: one-cycle pulse; access aborted.
- `err_code` out 2: `01` misaligned, `10` timeout, `11` illegal Funct3.
- `mem_req` out 1: memory request.
- `mem_we` out 4: byte write strobes. 0 for loads.
- `mem_addr` out ADDR_W: word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `mem_wdata` out 32: `req_wdata << (8*req_addr[1:0])`.
- `mem_rdata` in 32: read data. Valid with `mem_ack`.
- `mem_ack` in 1: completes the request.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On `req_valid`, latch `funct3`, `addr[1:0]` and `we`, and register the `mem_*` outputs.
  - Illegal Funct3 (a load with Funct3 3, 6 or 7, or a store with Funct3 other than 0, 1 or 2) goes to RESP with `err_code=11`, and no `mem_req` is issued.
  - Otherwise the block goes to ACCESS with `mem_req=1`.
- ACCESS:
  - `mem_req` stays high and `mem_*` stay stable until `mem_ack` is sampled high.
  - On ack: `mem_req` goes to 0, loads capture the extended data into `rd_data`, and the state goes to RESP.
  - If the wait counter reaches `TIMEOUT` (nonzero) with no ack: `mem_req` goes to 0, `rd_data` goes to 0, `err_code` goes to `10`, and the state goes to RESP.
  - A late ack after an abort is ignored.
- RESP:
  - `rd_valid` is 1 for loads with no error.
  - `err` is 1 if an error is latched.
  - `req_valid` is ignored, because it still belongs to the retiring instruction.
  - Next state is always IDLE.
- `stall = (IDLE & req_valid) | ACCESS`. `stall` is 0 in RESP.
- Store strobes, before the lane shift:
  - sb `0001`
  - sh `0011`
  - sw `1111`
  - The base pattern is shifted left by `addr[1:0]`, and bits beyond bit 3 are dropped.
- Load extraction: `d = mem_rdata >> (8*addr[1:0])`, then:
  - lb sign-extends `d[7:0]`.
  - lh sign-extends `d[15:0]`.
  - lw uses `d`.
  - lbu zero-extends `d[7:0]`.
  - lhu zero-extends `d[15:0]`.
- `rd_data` holds its value until the next successful load.

## Timing
- Reset values:
  - state IDLE
  - `stall`: 0 at reset when `req_valid=0`. It is combinational, so during reset it still follows `req_valid`.
  - all of `rd_valid`, `rd_data`, `err`, `err_code`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` at 0
- Reset during ACCESS drops `mem_req` immediately (asynchronously).
- All outputs are registered except `stall`.
- Minimum access with ack on the first `mem_req` cycle:
  - cycle 0: IDLE with `req_valid`, `stall=1`.
  - cycle 1: ACCESS with `mem_req` and `mem_ack`, `stall=1`.
  - cycle 2: RESP, `rd_valid=1`, `stall=0`.
  - Total: 2 stall cycles, and the instruction retires at the end of cycle 2.
- Each additional wait cycle adds one stall cycle.
- Timeout: RESP occurs `TIMEOUT+1` cycles after the IDLE acceptance.
- Error without access: RESP in cycle 1, with 1 stall cycle.
- Back-to-back accesses: a new `req_valid` is accepted in the IDLE cycle directly after RESP.

## Configuration
- The misaligned-access trap is compiled in with `LSU_MISALIGN_TRAP_EN`.
- With `LSU_MISALIGN_TRAP_EN` defined:
  - An access is misaligned if it is lw/sw with `addr[1:0]!=0`, or lh/lhu/sh with `addr[0]!=0`.
  - A misaligned access goes IDLE→RESP with `err_code=01`.
  - No `mem_req` is issued and `rd_data` is unchanged.
  - Illegal Funct3 takes priority over misalignment.
- Without it, misaligned accesses proceed. Strobes and data are truncated at the word boundary by the shift rules above.

## Test plan
- lb, `addr=0x103`, `mem_rdata=0x80FF_FFFF`, ack in the first ACCESS cycle → `rd_valid` in cycle 2 with `rd_data=0xFFFF_FF80`, `mem_addr=0x100`, and `stall` high for exactly 2 cycles.
- sh, `addr=0x202`, `wdata=0x0000_BEEF`, ack after 3 wait cycles → `mem_we=1100` and `mem_wdata=0xBEEF_0000` stable for 4 cycles, no `rd_valid`, 5 stall cycles.
- lhu, `addr=0x10`, `mem_rdata=0x1234_8765` → `rd_data=0x0000_8765`. lh at the same address → `rd_data=0xFFFF_8765`.
- `TIMEOUT=4`, lw, ack never asserted → `mem_req` high for 4 cycles, then `err=1` and `err_code=10` in RESP. A late ack is ignored, and the next lw completes normally.
- sw, `addr=0x6`:
  - With `LSU_MISALIGN_TRAP_EN`: `err_code=01` in cycle 1 and `mem_req` never asserted.
  - Without it: `mem_we=1100` and `mem_wdata=wdata<<16`.
- Load with Funct3 3 → `err_code=11` and no `mem_req`. Then assert `rst` mid-ACCESS on a following lw → `mem_req` and `stall` fall immediately and the state returns to IDLE.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: IDLE -> ACCESS -> RESP handshake with byte strobes and load extension.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned lw/sw/lh/lhu/sh instead of issuing them.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    logic [1:0]       state;
    logic [2:0]       f3_p1;
    logic [1:0]       lane_p1;
    logic             we_p1;
    logic [CNT_W-1:0] wait_cnt;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > 3'd2);
        else
            return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'd1:    return lane[0];
            2'd2:    return (lane != 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] lane);
        logic [3:0] base;
        case (f3[1:0])
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << lane;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] rdata);
        logic [31:0]        d;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        d  = rdata >> {lane, 3'b000};
        sb = d[7:0];
        sh = d[15:0];
        case (f3)
            3'd0:    sx = 32'(sb);
            3'd1:    sx = 32'(sh);
            3'd4:    sx = {24'd0, d[7:0]};
            3'd5:    sx = {16'd0, d[15:0]};
            default: sx = d;
        endcase
        return unsigned'(sx);
    endfunction

    assign stall = ((state == S_IDLE) && req_valid) || (state == S_ACCESS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            f3_p1     <= '0;
            lane_p1   <= '0;
            we_p1     <= 1'b0;
            wait_cnt  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rd_valid <= 1'b0;
            err      <= 1'b0;
            case (state)
                // p0 -> p1: accept and classify the request
                S_IDLE: begin
                    if (req_valid) begin
                        f3_p1    <= req_funct3;
                        lane_p1  <= req_addr[1:0];
                        we_p1    <= req_we;
                        wait_cnt <= '0;
                        if (is_illegal(req_we, req_funct3)) begin
                            err_code <= 2'b11;
                            err      <= 1'b1;
                            state    <= S_RESP;
                        end else if (MISALIGN_TRAP && is_misaligned(req_funct3, req_addr[1:0])) begin
                            err_code <= 2'b01;
                            err      <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            err_code  <= 2'b00;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                            state     <= S_ACCESS;
                        end
                    end
                end
                // p1 -> p2: wait for the memory, ack wins over a same-cycle timeout
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                        if (!we_p1) begin
                            rd_data  <= load_extend(f3_p1, lane_p1, mem_rdata);
                            rd_valid <= 1'b1;
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        mem_req  <= 1'b0;
                        rd_data  <= '0;
                        err_code <= 2'b10;
                        err      <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                // p2: retire; req_valid here still belongs to the retiring instruction
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed ops push expected memory requests and responses;
// a negedge monitor pops and compares whenever the DUT raises mem_req, rd_valid or err.
module tb_lsu_ctrl;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              stall;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              err;
    logic [1:0]        err_code;
    logic              mem_req;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack = 1'b0;

    lsu_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .err_code(err_code),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        logic [31:0] data;
        logic        chk_data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          cycles;
    } mreq_t;

    resp_t resp_q[$];
    mreq_t mem_q[$];
    int    tests = 0;
    int    fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: memory requests (content and hold length) and responses
    resp_t mon_r;
    mreq_t mon_m;
    logic  mon_active = 1'b0;
    logic  mreq_prev  = 1'b0;
    int    mon_cnt    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req) begin
                if (!mreq_prev) begin
                    if (mem_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", mem_addr);
                        mon_active = 1'b0;
                    end else begin
                        mon_m      = mem_q.pop_front();
                        mon_active = 1'b1;
                        mon_cnt    = 0;
                    end
                end
                if (mon_active) begin
                    mon_cnt++;
                    check("mem_addr", mem_addr, mon_m.addr);
                    check("mem_we", {28'd0, mem_we}, {28'd0, mon_m.we});
                    check("mem_wdata", mem_wdata, mon_m.wdata);
                end
            end
            if (rd_valid || err) begin
                if (resp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_resp: got rd_valid=%0b err=%0b, expected none", rd_valid, err);
                end else begin
                    mon_r = resp_q.pop_front();
                    check("rd_valid", {31'd0, rd_valid}, {31'd0, ~mon_r.is_err});
                    check("err", {31'd0, err}, {31'd0, mon_r.is_err});
                    if (mon_r.is_err)
                        check("err_code", {30'd0, err_code}, {30'd0, mon_r.code});
                    if (mon_r.chk_data)
                        check("rd_data", rd_data, mon_r.data);
                end
            end
        end
        if (!mem_req && mreq_prev && mon_active) begin
            check("mem_req_cycles", mon_cnt, mon_m.cycles);
            mon_active = 1'b0;
        end
        mreq_prev = mem_req;
    end

    // ack_wait < 0 means never ack; resp: 0 none, 1 load data, 2 error
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ack_wait, input int exp_stall, input int exp_mreq,
                          input logic [31:0] maddr, input logic [3:0] mwe, input logic [31:0] mwdata,
                          input int resp, input logic [1:0] code, input logic [31:0] data,
                          input logic chk_data, input string name);
        int stalls;
        int acc;
        int cyc;
        if (exp_mreq > 0)
            mem_q.push_back('{maddr, mwe, mwdata, exp_mreq});
        if (resp != 0)
            resp_q.push_back('{(resp == 2), code, data, chk_data});
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = rdata;
        mem_ack    = 1'b0;
        stalls = 0;
        acc    = 0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!stall) break;
            stalls++;
            if (mem_req) begin
                acc++;
                mem_ack = (ack_wait >= 0) && (acc == ack_wait + 1);
            end else begin
                mem_ack = 1'b0;
            end
            if (cyc > 40) begin
                tests++; fails++;
                $display("FAIL %s_hang: got stall after %0d cycles, expected completion", name, cyc);
                break;
            end
        end
        mem_ack = 1'b0;
        check({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("post_reset_rd_data", rd_data, 32'd0);
        check("post_reset_err", {31'd0, err}, 32'd0);
        check("post_reset_err_code", {30'd0, err_code}, 32'd0);
        check("post_reset_mem_we", {28'd0, mem_we}, 32'd0);
        check("post_reset_mem_addr", mem_addr, 32'd0);
        check("post_reset_mem_wdata", mem_wdata, 32'd0);

        //     we    f3    addr          wdata          rdata        ackw st mq maddr         mwe      mwdata        rsp code   data           chk
        run_op(1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 2, 1, 32'h0000_0100, 4'b0000, 32'h0,        1, 2'b00, 32'hFFFF_FF80, 1'b1, "lb_103");
        run_op(1'b1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        3, 5, 4, 32'h0000_0200, 4'b1100, 32'hBEEF_0000, 0, 2'b00, 32'h0,        1'b0, "sh_202");
        run_op(1'b0, 3'd5, 32'h0000_0010, 32'h0,        32'h1234_8765, 1, 3, 2, 32'h0000_0010, 4'b0000, 32'h0,        1, 2'b00, 32'h0000_8765, 1'b1, "lhu_10");
        run_op(1'b0, 3'd1, 32'h0000_0010, 32'h0,        32'h1234_8765, 0, 2, 1, 32'h0000_0010, 4'b0000, 32'h0,        1, 2'b00, 32'hFFFF_8765, 1'b1, "lh_10");
        run_op(1'b0, 3'd2, 32'h0000_0020, 32'h0,        32'h0,        -1, 5, 4, 32'h0000_0020, 4'b0000, 32'h0,        2, 2'b10, 32'h0,        1'b1, "lw_timeout");

        // late ack in idle must produce nothing
        @(posedge clk);
        #1 req_valid = 1'b0; mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_rd_valid", {31'd0, rd_valid}, 32'd0);

        run_op(1'b0, 3'd2, 32'h0000_0024, 32'h0,        32'hCAFE_F00D, 0, 2, 1, 32'h0000_0024, 4'b0000, 32'h0,        1, 2'b00, 32'hCAFE_F00D, 1'b1, "lw_24");
`ifdef LSU_MISALIGN_TRAP_EN
        run_op(1'b1, 3'd2, 32'h0000_0006, 32'h1122_3344, 32'h0,       -1, 1, 0, 32'h0,        4'b0000, 32'h0,        2, 2'b01, 32'hCAFE_F00D, 1'b1, "sw_6_trap");
`else
        run_op(1'b1, 3'd2, 32'h0000_0006, 32'h1122_3344, 32'h0,        0, 2, 1, 32'h0000_0004, 4'b1100, 32'h3344_0000, 0, 2'b00, 32'h0,        1'b0, "sw_6");
`endif
        run_op(1'b0, 3'd0, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 2, 1, 32'h0000_0000, 4'b0000, 32'h0,        1, 2'b00, 32'h0000_007F, 1'b1, "lb_1");
        run_op(1'b0, 3'd4, 32'h0000_0003, 32'h0,        32'hAB00_0000, 2, 4, 3, 32'h0000_0000, 4'b0000, 32'h0,        1, 2'b00, 32'h0000_00AB, 1'b1, "lbu_3");
        run_op(1'b1, 3'd0, 32'h0000_0003, 32'h0000_00A5, 32'h0,        0, 2, 1, 32'h0000_0000, 4'b1000, 32'hA500_0000, 0, 2'b00, 32'h0,        1'b0, "sb_3");
        run_op(1'b0, 3'd3, 32'h0000_0008, 32'h0,        32'h0,        -1, 1, 0, 32'h0,        4'b0000, 32'h0,        2, 2'b11, 32'h0,        1'b0, "ld_f3_3");
        run_op(1'b1, 3'd4, 32'h0000_0008, 32'h0,        32'h0,        -1, 1, 0, 32'h0,        4'b0000, 32'h0,        2, 2'b11, 32'h0,        1'b0, "st_f3_4");

        // reset in the middle of an access
        mem_q.push_back('{32'h0000_0040, 4'b0000, 32'h0, 1});
        @(posedge clk);
        #1 req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0040; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("mid_access_mem_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b1; req_valid = 1'b0;
        #1;
        check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("async_reset_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("after_reset_stall", {31'd0, stall}, 32'd0);

        run_op(1'b0, 3'd2, 32'h0000_0044, 32'h0,        32'h0000_0005, 0, 2, 1, 32'h0000_0044, 4'b0000, 32'h0,        1, 2'b00, 32'h0000_0005, 1'b1, "lw_44");

        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("resp_queue_drained", resp_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
